// File: rtl/vga_text_pkg.sv
// Shared constants and CPU-side FSM encoding for the text-mode VRAM arbiter.
package vga_text_pkg;
    localparam int VRAM_DEPTH  = 1200;
    localparam int VRAM_ADDR_W = 11;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_RD   = 2'd1,
        C_ACK  = 2'd2
    } cpu_state_t;
endpackage

// File: rtl/vga_vram_arbiter.sv
// Purpose: share one single-port text VRAM between Avalon CPU accesses and display fetches.
// Latency: display 1 cycle after grant (grant <=2 cycles after pend); CPU write 2 / read 3 cycles minimum.
// Backpressure: AVL_WAITREQUEST stalls the CPU; display is never stalled, an unserved fetch is overwritten (sticky overrun).
module vga_vram_arbiter
    import vga_text_pkg::*;
#(
    parameter int DEPTH        = VRAM_DEPTH,
    parameter int ADDR_W       = VRAM_ADDR_W,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              AVL_CS,
    input  logic              AVL_READ,
    input  logic              AVL_WRITE,
    input  logic [ADDR_W-1:0] AVL_ADDR,
    input  logic [3:0]        AVL_BYTE_EN,
    input  logic [DATA_W-1:0] AVL_WRITEDATA,
    output logic [DATA_W-1:0] AVL_READDATA,
    output logic              AVL_WAITREQUEST,
    input  logic              DISP_REQ,
    input  logic [ADDR_W-1:0] DISP_ADDR,
    output logic [DATA_W-1:0] DISP_RDATA,
    output logic              DISP_RVALID,
    output logic              DISP_OVERRUN,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic              RAM_WREN,
    output logic [3:0]        RAM_BYTEEN,
    output logic [DATA_W-1:0] RAM_WDATA,
    input  logic [DATA_W-1:0] RAM_Q
);
    localparam int               CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [ADDR_W:0]  DEPTH_LIM  = (ADDR_W + 1)'(DEPTH);

    cpu_state_t        state_q, state_d;
    logic              disp_pend_q, disp_pend_d;
    logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              overrun_q, overrun_d;
    logic              disp_rvalid_q, disp_rvalid_d;
    logic              disp_oob_q, disp_oob_d;
    logic              rd_oob_q, rd_oob_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic cpu_req, cpu_gnt, disp_gnt, cpu_in_range, disp_in_range;

    always_comb begin
        cpu_req       = AVL_CS & (AVL_READ | AVL_WRITE);
        cpu_in_range  = {1'b0, AVL_ADDR} < DEPTH_LIM;
        disp_in_range = {1'b0, disp_addr_q} < DEPTH_LIM;
        // Display owns the port unless the CPU has starved long enough; nothing is granted while in reset.
        cpu_gnt  = !RESET && (state_q == C_IDLE) && cpu_req &&
                   (!disp_pend_q || (starve_cnt_q >= STARVE_MAX));
        disp_gnt = !RESET && disp_pend_q && !cpu_gnt;

        state_d      = state_q;
        rd_oob_d     = rd_oob_q;
        rdata_d      = rdata_q;
        starve_cnt_d = starve_cnt_q;
        case (state_q)
            C_IDLE: begin
                if (cpu_gnt) begin
                    state_d      = AVL_WRITE ? C_ACK : C_RD;
                    rd_oob_d     = !cpu_in_range;
                    starve_cnt_d = '0;
                end else if (cpu_req && (starve_cnt_q < STARVE_MAX)) begin
                    starve_cnt_d = starve_cnt_q + 1'b1;
                end
            end
            C_RD: begin
                rdata_d = rd_oob_q ? '0 : RAM_Q;
                state_d = C_ACK;
            end
            C_ACK:   state_d = C_IDLE;
            default: state_d = C_IDLE;
        endcase

        // A request landing on a served pending fetch simply re-arms; only an unserved one is lost.
        disp_pend_d   = DISP_REQ | (disp_pend_q & !disp_gnt);
        disp_addr_d   = DISP_REQ ? DISP_ADDR : disp_addr_q;
        overrun_d     = overrun_q | (DISP_REQ & disp_pend_q & !disp_gnt);
        disp_rvalid_d = disp_gnt;
        disp_oob_d    = !disp_in_range;

        RAM_ADDR   = '0;
        RAM_WREN   = 1'b0;
        RAM_BYTEEN = '0;
        RAM_WDATA  = '0;
        if (cpu_gnt) begin
            if (cpu_in_range) begin
                RAM_ADDR = AVL_ADDR;
                if (AVL_WRITE) begin
                    RAM_WREN   = 1'b1;
                    RAM_BYTEEN = AVL_BYTE_EN;
                    RAM_WDATA  = AVL_WRITEDATA;
                end
            end
        end else if (disp_gnt && disp_in_range) begin
            RAM_ADDR = disp_addr_q;
        end

        AVL_WAITREQUEST = cpu_req & (state_q != C_ACK);
        AVL_READDATA    = rdata_q;
        DISP_RVALID     = disp_rvalid_q & !RESET;
        DISP_RDATA      = (disp_rvalid_q && !disp_oob_q && !RESET) ? RAM_Q : '0;
        DISP_OVERRUN    = overrun_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= C_IDLE;
            disp_pend_q   <= 1'b0;
            disp_addr_q   <= '0;
            starve_cnt_q  <= '0;
            overrun_q     <= 1'b0;
            disp_rvalid_q <= 1'b0;
            disp_oob_q    <= 1'b0;
            rd_oob_q      <= 1'b0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            disp_pend_q   <= disp_pend_d;
            disp_addr_q   <= disp_addr_d;
            starve_cnt_q  <= starve_cnt_d;
            overrun_q     <= overrun_d;
            disp_rvalid_q <= disp_rvalid_d;
            disp_oob_q    <= disp_oob_d;
            rd_oob_q      <= rd_oob_d;
            rdata_q       <= rdata_d;
        end
    end
endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Bench for vga_vram_arbiter: VRAM macro model, display/CPU scoreboards and cycle-exact timing checks.
module tb_vga_vram_arbiter;
    logic        CLK, RESET;
    logic        AVL_CS, AVL_READ, AVL_WRITE;
    logic [10:0] AVL_ADDR;
    logic [3:0]  AVL_BYTE_EN;
    logic [31:0] AVL_WRITEDATA, AVL_READDATA;
    logic        AVL_WAITREQUEST;
    logic        DISP_REQ;
    logic [10:0] DISP_ADDR;
    logic [31:0] DISP_RDATA;
    logic        DISP_RVALID, DISP_OVERRUN;
    logic [10:0] RAM_ADDR;
    logic        RAM_WREN;
    logic [3:0]  RAM_BYTEEN;
    logic [31:0] RAM_WDATA, RAM_Q;

    vga_vram_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
        .AVL_ADDR(AVL_ADDR), .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_WRITEDATA(AVL_WRITEDATA),
        .AVL_READDATA(AVL_READDATA), .AVL_WAITREQUEST(AVL_WAITREQUEST),
        .DISP_REQ(DISP_REQ), .DISP_ADDR(DISP_ADDR), .DISP_RDATA(DISP_RDATA),
        .DISP_RVALID(DISP_RVALID), .DISP_OVERRUN(DISP_OVERRUN),
        .RAM_ADDR(RAM_ADDR), .RAM_WREN(RAM_WREN), .RAM_BYTEEN(RAM_BYTEEN),
        .RAM_WDATA(RAM_WDATA), .RAM_Q(RAM_Q)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [31:0] mem     [0:2047];
    logic [31:0] ref_mem [0:2047];
    logic [31:0] disp_q[$];
    logic [31:0] cpu_q[$];
    bit          rv_hist [0:4095];
    logic [10:0] last_wr_addr;
    logic [31:0] last_wdata;
    logic [3:0]  last_be;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // VRAM macro: registered read, old data on read-during-write.
    always @(posedge CLK) begin
        RAM_Q <= mem[RAM_ADDR];
        if (RAM_WREN)
            for (int b = 0; b < 4; b++)
                if (RAM_BYTEEN[b]) mem[RAM_ADDR][8*b +: 8] <= RAM_WDATA[8*b +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    endtask

    always @(negedge CLK) begin
        if (cyc < 4096) rv_hist[cyc] = DISP_RVALID;
        if (DISP_RVALID) begin
            if (disp_q.size() == 0) chk("disp_spurious", {31'd0, DISP_RVALID}, 32'd0);
            else chk("disp_rdata", DISP_RDATA, disp_q.pop_front());
        end
    end

    task automatic ref_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] be);
        if (a < 11'd1200)
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic disp_req(input logic [10:0] a, output int c);
        DISP_REQ  = 1'b1;
        DISP_ADDR = a;
        disp_q.push_back(a < 11'd1200 ? ref_mem[a] : 32'h0);
        c = cyc;
        @(posedge CLK); #1;
        DISP_REQ = 1'b0;
    endtask

    task automatic cpu_op(input bit wr, input logic [10:0] a, input logic [31:0] d, input logic [3:0] be,
                          output int s_cyc, output int w_cyc, output int a_cyc, output int wcnt);
        bit done;
        AVL_CS = 1'b1; AVL_READ = !wr; AVL_WRITE = wr;
        AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
        if (wr) ref_write(a, d, be);
        else cpu_q.push_back(a < 11'd1200 ? ref_mem[a] : 32'h0);
        s_cyc = cyc; w_cyc = -1; a_cyc = -1; wcnt = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge CLK);
            if (RAM_WREN) begin
                wcnt++; w_cyc = cyc;
                last_wr_addr = RAM_ADDR; last_wdata = RAM_WDATA; last_be = RAM_BYTEEN;
            end
            if (!AVL_WAITREQUEST) begin
                done  = 1;
                a_cyc = cyc;
                if (!wr) chk("cpu_rdata", AVL_READDATA, cpu_q.pop_front());
            end
            @(posedge CLK); #1;
        end
        chk("cpu_done", {31'd0, done}, 32'd1);
        AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int s, w, a, n, c;
        bit done;
        for (int i = 0; i < 2048; i++) begin
            mem[i]     = 32'h5A00_0000 | i;
            ref_mem[i] = 32'h5A00_0000 | i;
        end
        RESET = 1'b1; AVL_CS = 0; AVL_READ = 0; AVL_WRITE = 0; AVL_ADDR = '0;
        AVL_BYTE_EN = '0; AVL_WRITEDATA = '0; DISP_REQ = 0; DISP_ADDR = '0;
        repeat (3) @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("rst_wren", {31'd0, RAM_WREN}, 32'd0);
        chk("rst_rvalid", {31'd0, DISP_RVALID}, 32'd0);
        chk("rst_waitreq", {31'd0, AVL_WAITREQUEST}, 32'd0);
        chk("rst_overrun", {31'd0, DISP_OVERRUN}, 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_readdata", AVL_READDATA, 32'd0);
        chk("rst_ram_addr", {21'd0, RAM_ADDR}, 32'd0);
        @(posedge CLK); #1;

        // Uncontended write then read, plus a partial byte-enable write.
        cpu_op(1, 11'd5, 32'hDEAD_BEEF, 4'hF, s, w, a, n);
        chk("t1_wr_lat", a - s + 1, 32'd2);
        chk("t1_wren_cyc", w - s, 32'd0);
        chk("t1_wren_cnt", n, 32'd1);
        chk("t1_wr_addr", {21'd0, last_wr_addr}, 32'd5);
        chk("t1_wdata", last_wdata, 32'hDEAD_BEEF);
        chk("t1_be", {28'd0, last_be}, 32'hF);
        cpu_op(0, 11'd5, 32'h0, 4'hF, s, w, a, n);
        chk("t1_rd_lat", a - s + 1, 32'd3);
        chk("t1_rd_wren", n, 32'd0);
        cpu_op(1, 11'd6, 32'h1122_3344, 4'h5, s, w, a, n);
        chk("t1_be_part", {28'd0, last_be}, 32'h5);
        cpu_op(0, 11'd6, 32'h0, 4'hF, s, w, a, n);

        // Out-of-range accesses.
        cpu_op(0, 11'd1300, 32'h0, 4'hF, s, w, a, n);
        chk("t5_rd_lat", a - s + 1, 32'd3);
        chk("t5_rd_wren", n, 32'd0);
        cpu_op(1, 11'd1200, 32'h1234_5678, 4'hF, s, w, a, n);
        chk("t5_wr_lat", a - s + 1, 32'd2);
        chk("t5_wr_wren", n, 32'd0);
        disp_req(11'd1250, c);
        repeat (3) begin @(posedge CLK); #1; end
        chk("t5_disp_rv", {31'd0, rv_hist[c+2]}, 32'd1);

        // Display collides with a CPU read: display first, CPU one cycle later.
        disp_req(11'd10, c);
        cpu_op(0, 11'd3, 32'h0, 4'hF, s, w, a, n);
        chk("t2_rd_lat", a - s + 1, 32'd4);
        chk("t2_rv_at_s", {31'd0, rv_hist[s]}, 32'd0);
        chk("t2_rv_next", {31'd0, rv_hist[s+1]}, 32'd1);

        // Back-to-back fetches without CPU traffic.
        disp_req(11'd30, c);
        disp_req(11'd31, n);
        repeat (4) begin @(posedge CLK); #1; end
        chk("t4_rv_c1", {31'd0, rv_hist[c+1]}, 32'd0);
        chk("t4_rv_c2", {31'd0, rv_hist[c+2]}, 32'd1);
        chk("t4_rv_c3", {31'd0, rv_hist[c+3]}, 32'd1);
        chk("t4_rv_c4", {31'd0, rv_hist[c+4]}, 32'd0);
        chk("t4_overrun", {31'd0, DISP_OVERRUN}, 32'd0);

        // Display every cycle while the CPU writes: starvation override.
        fork
            begin
                for (int i = 0; i < 14; i++) begin
                    DISP_REQ = 1'b1; DISP_ADDR = 11'd20;
                    disp_q.push_back(ref_mem[20]);
                    @(posedge CLK); #1;
                end
                DISP_REQ = 1'b0;
            end
            begin
                @(posedge CLK); #1;
                cpu_op(1, 11'd40, 32'hCAFE_F00D, 4'hF, s, w, a, n);
            end
        join
        repeat (3) begin @(posedge CLK); #1; end
        chk("t3_wren_cyc", w - s, 32'd8);
        chk("t3_wr_lat", a - s + 1, 32'd10);
        chk("t3_wdata", last_wdata, 32'hCAFE_F00D);
        chk("t3_rv_at_gnt", {31'd0, rv_hist[w]}, 32'd1);
        chk("t3_rv_gap", {31'd0, rv_hist[a]}, 32'd0);
        chk("t3_rv_resume", {31'd0, rv_hist[a+1]}, 32'd1);
        chk("t3_overrun", {31'd0, DISP_OVERRUN}, 32'd1);
        chk("t3_drop_one", disp_q.size(), 32'd1);
        disp_q.delete();

        // Reset while the CPU read is in C_RD with a display fetch pending.
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b0; AVL_ADDR = 11'd7;
        DISP_REQ = 1'b1; DISP_ADDR = 11'd50;
        @(negedge CLK);
        chk("t6_wait_pre", {31'd0, AVL_WAITREQUEST}, 32'd1);
        @(posedge CLK); #1;
        DISP_REQ = 1'b0; RESET = 1'b1;
        @(negedge CLK);
        chk("t6_rst_wren", {31'd0, RAM_WREN}, 32'd0);
        chk("t6_rst_addr", {21'd0, RAM_ADDR}, 32'd0);
        chk("t6_rst_rvalid", {31'd0, DISP_RVALID}, 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk("t6_rvalid", {31'd0, DISP_RVALID}, 32'd0);
        chk("t6_waitreq", {31'd0, AVL_WAITREQUEST}, 32'd1);
        chk("t6_overrun", {31'd0, DISP_OVERRUN}, 32'd0);
        chk("t6_readdata", AVL_READDATA, 32'd0);
        chk("t6_cpu_addr", {21'd0, RAM_ADDR}, 32'd7);
        @(posedge CLK); #1;
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge CLK);
            if (!AVL_WAITREQUEST) begin
                done = 1;
                chk("t6_rdata", AVL_READDATA, ref_mem[7]);
            end
            @(posedge CLK); #1;
        end
        chk("t6_done", {31'd0, done}, 32'd1);
        AVL_CS = 1'b0; AVL_READ = 1'b0;
        repeat (3) begin @(posedge CLK); #1; end
        chk("disp_drain", disp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
